// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN-order car controller; latches floor calls and drives motor/door.
// In: clk, rst_n, sw, close, [door_hold with DOOR_HOLD_EN], floor. Out: dir, move, door, pending.
module elevator_scan_ctrl #(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 16,
  parameter int TMR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] sw,
  input  logic                close,
`ifdef DOOR_HOLD_EN
  input  logic                door_hold,
`endif
  input  logic [FLOOR_W-1:0]  floor,
  output logic                dir,
  output logic                move,
  output logic                door,
  output logic [N_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;

  logic                above, below, here, sw_here;
  logic                ahead, behind, hold;
  logic [N_FLOORS-1:0] at_vec;

`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Out-of-range floor never matches any index, so all flags stay 0.
  always_comb begin
    above   = 1'b0;
    below   = 1'b0;
    here    = 1'b0;
    sw_here = 1'b0;
    at_vec  = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && i > int'(floor)) above = 1'b1;
      if (pending_q[i] && i < int'(floor)) below = 1'b1;
      if (i == int'(floor)) begin
        at_vec[i] = 1'b1;
        sw_here   = sw[i];
        here      = pending_q[i] | sw[i];
      end
    end
  end

  assign ahead  = dir_q ? above : below;
  assign behind = dir_q ? below : above;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR;
          timer_d = TMR_W'(DOOR_CYCLES - 1);
        end else if (ahead) begin
          state_d = MOVE;
        end else if (behind) begin
          state_d = MOVE;
          dir_d   = ~dir_q;
        end
      end
      MOVE: begin
        if (here) begin
          state_d = DOOR;
          timer_d = TMR_W'(DOOR_CYCLES - 1);
        end else if (!ahead) begin
          state_d = IDLE;
        end
      end
      DOOR: begin
        // A call at this floor outranks close and hold.
        if (sw_here) begin
          timer_d = TMR_W'(DOOR_CYCLES - 1);
        end else if (hold) begin
          timer_d = timer_q;
        end else if (close || timer_q == '0) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The open floor's bit is masked so its calls only refresh the timer.
    pending_d = pending_q | sw;
    if (state_d == DOOR) pending_d = pending_d & ~at_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 1'b1;
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign dir     = dir_q;
  assign move    = (state_q == MOVE);
  assign door    = (state_q == DOOR);
  assign pending = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: random + directed stimulus against a behavioural SCAN model.
// A sensor model advances floor while the car is moving.
module tb_elevator_scan_ctrl;

  localparam int NF = 8;
  localparam int DC = 16;
  localparam int P_IDLE = 0;
  localparam int P_MOVE = 1;
  localparam int P_DOOR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] sw_v = '0;
  logic          close_v = 1'b0;
  logic [2:0]    floor_v = '0;
  logic          dir, move, door;
  logic [NF-1:0] pending;
`ifdef DOOR_HOLD_EN
  logic          hold_v = 1'b0;
`endif

  elevator_scan_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw_v),
    .close    (close_v),
`ifdef DOOR_HOLD_EN
    .door_hold(hold_v),
`endif
    .floor    (floor_v),
    .dir      (dir),
    .move     (move),
    .door     (door),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit [NF-1:0] m_pend;
  bit          m_dir;
  int          m_phase;
  int          m_left;
  int          flr = 0;
  int          tick = 0;
  int          step_per = 10;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_dir   = 1'b1;
    m_phase = P_IDLE;
    m_left  = 0;
    tick    = 0;
  endtask

  task automatic model_step();
    int f;
    bit up, dn, here, swh, hl;
    f  = int'(floor_v);
    up = 0;
    dn = 0;
    for (int i = 0; i < NF; i++)
      if (m_pend[i]) begin
        if (i > f) up = 1;
        if (i < f) dn = 1;
      end
    here = m_pend[f] | sw_v[f];
    swh  = sw_v[f];
    hl   = 0;
`ifdef DOOR_HOLD_EN
    hl = hold_v;
`endif
    m_pend = m_pend | sw_v;
    case (m_phase)
      P_IDLE: begin
        if (here) begin
          m_phase = P_DOOR;
          m_left  = DC;
        end else if (m_dir ? up : dn) begin
          m_phase = P_MOVE;
        end else if (m_dir ? dn : up) begin
          m_dir   = !m_dir;
          m_phase = P_MOVE;
        end
      end
      P_MOVE: begin
        if (here) begin
          m_phase = P_DOOR;
          m_left  = DC;
        end else if (!(m_dir ? up : dn)) begin
          m_phase = P_IDLE;
        end
      end
      default: begin
        if (swh) m_left = DC;
        else if (hl) m_left = m_left;
        else if (close_v || m_left == 1) m_phase = P_IDLE;
        else m_left--;
      end
    endcase
    if (m_phase == P_DOOR) m_pend[f] = 1'b0;
  endtask

  task automatic step(input logic [NF-1:0] s, input logic c);
    check("dir", dir, m_dir);
    check("move", move, m_phase == P_MOVE);
    check("door", door, m_phase == P_DOOR);
    check("pending", pending, m_pend);
    if (m_phase == P_MOVE) begin
      if (tick >= step_per - 1) begin
        tick = 0;
        if (m_dir && flr < NF - 1) flr++;
        else if (!m_dir && flr > 0) flr--;
      end else begin
        tick++;
      end
    end else begin
      tick = 0;
    end
    sw_v    = s;
    close_v = c;
    floor_v = 3'(flr);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic areset_check();
    #2 rst_n = 1'b0;
    #1;
    check("rst_move", move, 1'b0);
    check("rst_door", door, 1'b0);
    check("rst_pend", pending, '0);
    check("rst_dir", dir, 1'b1);
    model_reset();
    sw_v    = '0;
    close_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_door(input int bound);
    for (int k = 0; k < bound && m_phase != P_DOOR; k++) step('0, 1'b0);
    check("door_to", door, 1'b1);
  endtask

  task automatic run_to_idle(input int bound);
    for (int k = 0; k < bound && !(m_phase == P_IDLE && m_pend == '0); k++)
      step('0, 1'b0);
    check("idle_to", {move, door, pending}, '0);
  endtask

  initial begin
    logic [NF-1:0] s;
    logic          cl;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Travel 0 -> 7 with 10-cycle floor steps, door holds 16 cycles.
    step_per = 10;
    step(8'h80, 1'b0);
    run_to_door(200);
    run_to_idle(40);

    // Door at floor 3 closed early by close at timer 10.
    step(8'h08, 1'b0);
    run_to_door(200);
    for (int k = 0; k < 20 && m_left != 11; k++) step('0, 1'b0);
    step('0, 1'b1);
    step('0, 1'b0);
    check("close_door", door, 1'b0);
    run_to_idle(10);

    // Up toward 7, call to 0 arrives at floor 4: serve 7 then 0.
    step(8'h80, 1'b0);
    for (int k = 0; k < 300 && !(flr == 4 && m_phase == P_MOVE); k++)
      step('0, 1'b0);
    step(8'h01, 1'b0);
    run_to_idle(600);
    check("final_floor", 32'(flr), 32'd0);

    // Repeated call at the open floor keeps door open, pending clear.
    step(8'h04, 1'b0);
    run_to_door(200);
    for (int k = 0; k < 50; k++) begin
      step((k % 10 == 0) ? 8'h04 : 8'h00, 1'b0);
      check("hold_open", door, 1'b1);
      check("no_pend2", pending[2], 1'b0);
    end
    run_to_idle(40);

`ifdef DOOR_HOLD_EN
    step(8'h20, 1'b0);
    run_to_door(200);
    hold_v = 1'b1;
    for (int k = 0; k < 40; k++) step('0, k == 20);
    hold_v = 1'b0;
    run_to_idle(40);
`endif

    // Randomised traffic with periodic asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      s = '0;
      if ($urandom_range(0, 9) == 0) s[$urandom_range(0, NF - 1)] = 1'b1;
      if (m_phase == P_DOOR && $urandom_range(0, 15) == 0) s[flr] = 1'b1;
      cl = ($urandom_range(0, 19) == 0);
      if (c % 100 == 0) step_per = int'($urandom_range(1, 4));
      step(s, cl);
      if (c % 377 == 376) areset_check();
    end

    // Reset mid-MOVE with pending 8'h60 clears everything at once.
    run_to_idle(600);
    flr      = 0;
    step_per = 10;
    step(8'h60, 1'b0);
    for (int k = 0; k < 20 && m_phase != P_MOVE; k++) step('0, 1'b0);
    step('0, 1'b0);
    check("pre_rst_move", move, 1'b1);
    check("pre_rst_pend", pending, 32'h60);
    areset_check();
    step('0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
Parametrised elevator car controller for N floors, successor to the fixed 8-floor `state` controller. It latches floor-call requests into a pending vector and serves them in SCAN order, continuing in the current direction while requests remain ahead. It drives motor enable/direction and a timed door output. The block sits between the floor-switch debouncers and the motor/door drivers; the current floor comes from an external position sensor.

Parameters:
N_FLOORS, 8, number of floors; minimum 2.
FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= N_FLOORS.
DOOR_CYCLES, 16, clock cycles the door stays open; minimum 2.
TMR_W, 8, door timer width; must satisfy 2**TMR_W > DOOR_CYCLES.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
sw  input  N_FLOORS  floor-call switches; level or pulse; bit i = call to floor i.
close  input  1  door-close button; active high.
floor  input  FLOOR_W  sensed current car floor.
dir  output  1  travel direction; 1 = up, 0 = down.
move  output  1  motor enable.
door  output  1  door open.
pending  output  N_FLOORS  latched outstanding requests.

Behaviour:
- Reset:
  - Asserting rst_n low immediately forces state IDLE, pending = 0, timer = 0, dir = 1, move = 0, door = 0.
  - Reset mid-travel or mid-door discards all requests.
- Request latch: each cycle, pending_next = (pending | sw) & ~clr.
  - clr is the one-hot bit of floor when the door opens or is held open at that floor.
  - Latency: a sw bit is visible on pending one cycle after it is sampled.
  - A request for the floor where the door is currently open never sets pending; it reloads the door timer instead.
- Derived signals, combinational from pending and floor:
  - above = any pending bit with index > floor.
  - below = any pending bit with index < floor.
  - here = pending[floor] | sw[floor].
  - If floor >= N_FLOORS, all three are 0.
- States: IDLE, MOVE, DOOR. Outputs are registered: move = 1 only in MOVE; door = 1 only in DOOR.
- IDLE:
  - If here: go to DOOR and load timer = DOOR_CYCLES-1.
  - Else if the request ahead in the current dir exists (above when dir=1, below when dir=0): go to MOVE, dir unchanged.
  - Else if the request behind exists: toggle dir, go to MOVE.
  - Else stay in IDLE.
- MOVE:
  - If here: go to DOOR next cycle (move drops, door rises in the same cycle) and load the timer.
  - Else if there is no request ahead in dir: go to IDLE. This is the safety stop; the sensor overshot or the request was withdrawn by reset.
  - floor reaching 0 while dir=0, or N_FLOORS-1 while dir=1, with no request there: go to IDLE.
- DOOR:
  - The timer decrements each cycle.
  - sw[floor] asserted: reload the timer to DOOR_CYCLES-1. A call at the current floor takes priority over close in the same cycle.
  - close asserted with no sw[floor]: force timer = 0.
  - Timer == 0: go to IDLE. The door closes, so door is open for exactly DOOR_CYCLES cycles absent other inputs. The IDLE decision is taken the following cycle.
- Simultaneous requests are all latched; service order is nearest-in-direction first, by construction of SCAN.

Optional Feature:
- Macro: DOOR_HOLD_EN.
- Defined:
  - Adds input port door_hold (1 bit), placed after close.
  - While door_hold=1 in DOOR, the timer is frozen and close is ignored.
  - door_hold asserted in IDLE with here: enter DOOR as normal.
- Undefined: the port is absent and the behaviour is exactly as above.

Test Plan (N_FLOORS=8, DOOR_CYCLES=16):
- Reset, floor=0, pulse sw=8'b1000_0000 for 1 cycle:
  - pending=8'h80 next cycle, dir=1, move=1.
  - Drive floor 1..7 at 10-cycle steps; at floor=7, door=1 and move=0 within 1 cycle.
  - pending=0; door stays 1 for 16 cycles.
- Door open at floor 3, assert close 1 cycle at timer=10: door=0 on the following cycle; controller returns to IDLE.
- Floor=4, moving up toward 7, sw=8'h01 arrives: the car stops at 7 first.
  - After the door cycle, dir flips to 0, move=1; the car serves floor 0 and pending ends at 0.
- Door open at floor 2, sw=8'h04 pulsed every 10 cycles for 50 cycles: door stays 1 throughout; pending[2] never sets.
- Reset asserted mid-MOVE with pending=8'h60: move, door and pending = 0 immediately, before the next clk edge.
- DOOR_HOLD_EN defined, door open, door_hold=1 for 40 cycles plus a close pulse: door stays 1; closes 16 cycles after door_hold falls.
